// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the round-robin issue arbiter.
package arb_pkg;
  localparam int ARB_NUM_REQ = 16;
  localparam int ARB_IDX_W   = 4;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_t;
endpackage

// File: rtl/dec4.sv
// 4-to-16 one-hot decoder with enable; output is all zero when disabled.
module dec4 (
  input  logic        i_en,
  input  logic [3:0]  i_sel,
  output logic [15:0] o_dec
);
  always_comb begin
    o_dec = '0;
    if (i_en) o_dec[i_sel] = 1'b1;
  end
endmodule

// File: rtl/rr_issue_arbiter.sv
// 16-way round-robin arbiter with a held valid/ready grant onto one shared port.
// Optional ARB_LOCK_EN adds gnt_lock: re-grant the same requester on accept.
//
// state    | meaning
// ARB_IDLE | no grant presented; waiting for any request
// ARB_HOLD | grant presented in gnt_idx/gnt until gnt_ready
module rr_issue_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ = ARB_NUM_REQ,
  parameter int IDX_W   = ARB_IDX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               gnt_ready,
`ifdef ARB_LOCK_EN
  input  logic               gnt_lock,
`endif
  output logic               gnt_valid,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic [NUM_REQ-1:0] gnt
);

  arb_state_t       r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_gnt_idx;
  logic             r_gnt_valid;

  logic             w_accept;
  logic             w_lock;
  logic [IDX_W-1:0] w_next_ptr;
  logic [IDX_W-1:0] w_base;
  logic             w_any;
  logic [IDX_W-1:0] w_sel;

  // Nearest set bit at or above start, wrapping; scanning downward lets the
  // closest candidate overwrite farther ones.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] req_v,
                                             input logic [IDX_W-1:0]   start);
    logic [IDX_W-1:0] idx;
    rr_pick = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = start + IDX_W'(i);
      if (req_v[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

  assign w_accept   = (r_state == ARB_HOLD) && gnt_ready;
  assign w_next_ptr = r_gnt_idx + IDX_W'(1);

`ifdef ARB_LOCK_EN
  assign w_lock = w_accept && gnt_lock && req[r_gnt_idx];
`else
  assign w_lock = 1'b0;
`endif

  // On accept the search already uses the advanced pointer, so the next
  // winner lands without a bubble cycle.
  assign w_base         = (r_state == ARB_HOLD) ? w_next_ptr : r_ptr;
  assign {w_any, w_sel} = rr_pick(req, w_base);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ARB_IDLE;
      r_ptr       <= '0;
      r_gnt_idx   <= '0;
      r_gnt_valid <= 1'b0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_any) begin
            r_gnt_idx   <= w_sel;
            r_gnt_valid <= 1'b1;
            r_state     <= ARB_HOLD;
          end
        end
        ARB_HOLD: begin
          if (w_accept && !w_lock) begin
            r_ptr <= w_next_ptr;
            if (w_any) begin
              r_gnt_idx <= w_sel;
            end else begin
              r_gnt_valid <= 1'b0;
              r_state     <= ARB_IDLE;
            end
          end
        end
        default: begin
          r_state     <= ARB_IDLE;
          r_gnt_valid <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_valid = r_gnt_valid;
  assign gnt_idx   = r_gnt_idx;

  dec4 u_dec4 (
    .i_en  (r_gnt_valid),
    .i_sel (r_gnt_idx),
    .o_dec (gnt)
  );

endmodule

// File: tb/tb_rr_issue_arbiter.sv
// Scoreboard bench for rr_issue_arbiter: expected accepted indices are queued
// by the stimulus and popped by a monitor on every accept cycle.
module tb_rr_issue_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req;
  logic        gnt_ready;
  logic        gnt_valid;
  logic [3:0]  gnt_idx;
  logic [15:0] gnt;
`ifdef ARB_LOCK_EN
  logic        gnt_lock;
`endif

  int         n_vec = 0;
  int         n_err = 0;
  logic [3:0] exp_q[$];

  rr_issue_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt_ready (gnt_ready),
`ifdef ARB_LOCK_EN
    .gnt_lock  (gnt_lock),
`endif
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .gnt       (gnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic chk_grant(input string name, input logic v, input logic [3:0] idx);
    @(negedge clk);
    check({name, "_valid"}, {31'd0, gnt_valid}, {31'd0, v});
    if (v) check({name, "_idx"}, {28'd0, gnt_idx}, {28'd0, idx});
    check({name, "_gnt"}, {16'd0, gnt}, v ? (32'h1 << idx) : 32'h0);
  endtask

  // Monitor: every accepted grant must match the next queued expectation.
  always @(negedge clk) begin
    logic [3:0] e;
    if (!rst && gnt_valid === 1'b1 && gnt_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_accept: got idx %0d expected none", gnt_idx);
      end else begin
        e = exp_q.pop_front();
        check("accept_idx", {28'd0, gnt_idx}, {28'd0, e});
        check("accept_gnt", {16'd0, gnt}, 32'h1 << e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    req       = '0;
    gnt_ready = 1'b0;
`ifdef ARB_LOCK_EN
    gnt_lock  = 1'b0;
`endif
    repeat (3) step();
    rst = 1'b0;

    // idle after reset, then a single request
    repeat (5) chk_grant("idle", 1'b0, 4'd0);
    step();
    req = 16'h0020;
    step();
    chk_grant("first", 1'b1, 4'd5);
    step();
    req = 16'h0000; gnt_ready = 1'b1; exp_q.push_back(4'd5);
    step();
    gnt_ready = 1'b0;

    // hold: ptr=6, req 0x0021 wraps to idx 0; not preempted, not withdrawn
    req = 16'h0021;
    step();
    repeat (4) chk_grant("hold", 1'b1, 4'd0);
    step();
    req = 16'h0020;
    repeat (2) chk_grant("hold_drop", 1'b1, 4'd0);
    step();
    gnt_ready = 1'b1; exp_q.push_back(4'd0);
    step();
    exp_q.push_back(4'd5); req = 16'h0000;
    step();
    gnt_ready = 1'b0;
    check("hold_drain", exp_q.size(), 0);

    // rotation with every requester active: 0..15,0 with no bubbles
    reset_pulse();
    req = 16'hFFFF; gnt_ready = 1'b1;
    for (int i = 0; i < 17; i++) exp_q.push_back(4'(i % 16));
    step();
    repeat (16) step();
    req = 16'h0000;
    step();
    gnt_ready = 1'b0;
    check("rot_drain", exp_q.size(), 0);

    // wrap: ptr=1, grant 14; after its accept ptr=15 wraps to 0, then 14
    req = 16'h4000;
    step();
    chk_grant("wrap_first", 1'b1, 4'd14);
    step();
    req = 16'h4001; gnt_ready = 1'b1;
    exp_q.push_back(4'd14); exp_q.push_back(4'd0); exp_q.push_back(4'd14);
    step();
    step();
    req = 16'h0000;
    step();
    gnt_ready = 1'b0;
    check("wrap_drain", exp_q.size(), 0);

    // async reset mid-hold: ptr=15 so req 0x0200 grants 9
    req = 16'h0200;
    step();
    chk_grant("pre_rst", 1'b1, 4'd9);
    step();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", {31'd0, gnt_valid}, 32'd0);
    check("async_rst_gnt", {16'd0, gnt}, 32'd0);
    check("async_rst_idx", {28'd0, gnt_idx}, 32'd0);
    step();
    rst = 1'b0; req = 16'h0300;
    step();
    chk_grant("post_rst", 1'b1, 4'd8);
    step();
    req = 16'h0000; gnt_ready = 1'b1; exp_q.push_back(4'd8);
    step();
    gnt_ready = 1'b0;

    // lock sequence from ptr=0 with req 0x0006
    reset_pulse();
    req = 16'h0006; gnt_ready = 1'b1;
`ifdef ARB_LOCK_EN
    gnt_lock = 1'b1;
    exp_q.push_back(4'd1); exp_q.push_back(4'd1);
    exp_q.push_back(4'd1); exp_q.push_back(4'd2);
    step();
    step();
    step();
    gnt_lock = 1'b0;
    step();
    req = 16'h0000;
    step();
`else
    exp_q.push_back(4'd1); exp_q.push_back(4'd2); exp_q.push_back(4'd1);
    step();
    step();
    step();
    req = 16'h0000;
    step();
`endif
    gnt_ready = 1'b0;
    step();
    chk_grant("final_idle", 1'b0, 4'd0);
    check("final_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
